pin_expand_seq: RTL and testbench

- Sequential scatter unit: the inverse of the pin compress operation.
- Takes a packed value whose meaningful bits sit at the LSBs, and deposits them, in order, into the bit positions set in a pin mask. All other result bits are zero.
- Scans one pin position per cycle with a valid/ready handshake on both sides.
- Sits between a core's packed I/O value and the pin mux, driving output pins that are selected by a sparse mask.

---
 rtl/pin_expand_seq_pkg.sv | 16 +
 rtl/pin_expand_seq.sv | 108 ++++++++++
 tb/tb_pin_expand_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_expand_seq_pkg.sv
// Shared definitions for the sequential pin-expand (scatter) unit.
`ifndef IO_PINS
`define IO_PINS 38
`endif

package pin_expand_seq_pkg;

  localparam int unsigned IO_PINS = `IO_PINS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pin_expand_seq.sv
// Sequential scatter: deposits the low packed bits of in_data, in order, into
// the pin positions set in in_mask, scanning one pin per clock.
module pin_expand_seq
  import pin_expand_seq_pkg::*;
#(
  parameter int unsigned PINS = IO_PINS,
  parameter int unsigned CW   = $clog2(PINS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PINS-1:0] in_data,
  input  logic [PINS-1:0] in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PINS-1:0] out_result,
  output logic [CW-1:0]   out_count,
  output logic            busy
);

  localparam int unsigned PW = (PINS > 1) ? $clog2(PINS) : 1;

  state_e          state_q, state_d;
  logic [PINS-1:0] data_q, data_d;
  logic [PINS-1:0] mask_q, mask_d;
  logic [PINS-1:0] result_q, result_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      result_q <= '0;
      pos_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      pos_q    <= pos_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    result_d = result_q;
    pos_d    = pos_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          mask_d   = in_mask;
          result_d = '0;
          pos_d    = '0;
          count_d  = '0;
          state_d  = (in_mask == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mask_q[pos_q]) begin
          result_d[pos_q] = data_q[0];
          data_d          = data_q >> 1;
          count_d         = count_q + CW'(1);
          mask_d[pos_q]   = 1'b0;
        end
        // Termination keys off the remaining mask, so pos stops at the top pin.
        if (pos_q != PW'(PINS - 1)) begin
          pos_d = pos_q + PW'(1);
        end
        if (mask_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d  = ST_IDLE;
      data_d   = '0;
      mask_d   = '0;
      result_d = '0;
      pos_d    = '0;
      count_d  = '0;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_SCAN);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_pin_expand_seq.sv
// Directed bench for pin_expand_seq at PINS = 16.
module tb_pin_expand_seq;

  localparam int unsigned PINS = 16;
  localparam int unsigned CW   = $clog2(PINS + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [PINS-1:0] in_data = '0;
  logic [PINS-1:0] in_mask = '0;
  logic            in_ready;
  logic            out_valid;
  logic            busy;
  logic [PINS-1:0] out_result;
  logic [CW-1:0]   out_count;

  pin_expand_seq #(.PINS(PINS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] data;
    logic [15:0] mask;
    logic [15:0] res;
    int          cnt;
    int          lat;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] compress(input logic [15:0] v, input logic [15:0] m);
    logic [15:0] r;
    int j;
    r = '0;
    j = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        r[j] = v[i];
        j++;
      end
    end
    return r;
  endfunction

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    logic [15:0] low;
    wait_in_ready();
    in_data  = v.data;
    in_mask  = v.mask;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~v.data;
    in_mask  = ~v.mask;
    wait_out_valid(lat);
    chk($sformatf("v%0d_result", idx), {16'd0, out_result}, {16'd0, v.res});
    chk($sformatf("v%0d_count", idx), {27'd0, out_count}, v.cnt);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    low = (v.cnt >= 16) ? v.data : (v.data & 16'((32'd1 << v.cnt) - 1));
    chk($sformatf("v%0d_compress_back", idx), {16'd0, compress(out_result, v.mask)}, {16'd0, low});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("v%0d_in_ready_after", idx), {31'd0, in_ready}, 32'd1);
  endtask

  task automatic abort_case(input bit use_reset);
    int seen;
    string tag;
    tag = use_reset ? "rst" : "flush";
    seen = 0;
    wait_in_ready();
    in_data  = 16'hFFFF;
    in_mask  = 16'h8001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy_in_scan"}, {31'd0, busy}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    if (use_reset) begin
      #3 rst_n = 1'b0;
      #1;
    end else begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_out_result"}, {16'd0, out_result}, 32'd0);
    chk({tag, "_out_count"}, {27'd0, out_count}, 32'd0);
    if (use_reset) begin
      #2 rst_n = 1'b1;
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk({tag, "_out_valid_never"}, seen, 32'd0);
    chk({tag, "_idle_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int acc[3];
    int lats[3];
    int b2b[3];

    vt[0] = '{data: 16'h001B, mask: 16'h4945, res: 16'h0905, cnt: 6,  lat: 15};
    vt[1] = '{data: 16'hFFFF, mask: 16'h0000, res: 16'h0000, cnt: 0,  lat: 0};
    vt[2] = '{data: 16'hA5C3, mask: 16'hFFFF, res: 16'hA5C3, cnt: 16, lat: 16};
    vt[3] = '{data: 16'hFFFF, mask: 16'h0001, res: 16'h0001, cnt: 1,  lat: 1};
    vt[4] = '{data: 16'h0003, mask: 16'h8000, res: 16'h8000, cnt: 1,  lat: 16};
    vt[5] = '{data: 16'hFFFF, mask: 16'h00F0, res: 16'h00F0, cnt: 4,  lat: 8};
    vt[6] = '{data: 16'h0005, mask: 16'h0A0A, res: 16'h0202, cnt: 4,  lat: 12};

    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_result", {16'd0, out_result}, 32'd0);
    chk("reset_out_count", {27'd0, out_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Backpressure in DONE with a competing offer on the input side.
    wait_in_ready();
    in_data  = 16'h0002;
    in_mask  = 16'h0006;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(lat);
    chk("bp_latency", lat, 32'd3);
    in_data  = 16'hFFFF;
    in_mask  = 16'hFFFF;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_result_%0d", k), {16'd0, out_result}, 32'h0004);
      chk($sformatf("bp_hold_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_hold_out_valid_%0d", k), {31'd0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    chk("bp_result_kept_idle", {16'd0, out_result}, 32'h0004);
    chk("bp_count_kept_idle", {27'd0, out_count}, 32'd2);

    abort_case(1'b0);
    abort_case(1'b1);

    // Back-to-back with out_ready tied high and in_valid held.
    b2b[0] = 0; b2b[1] = 4; b2b[2] = 3;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_in_ready();
      in_data = vt[b2b[k]].data;
      in_mask = vt[b2b[k]].mask;
      @(posedge clk); #1;
      acc[k] = int'(cyc);
      if (k == 2) in_valid = 1'b0;
      wait_out_valid(lats[k]);
      chk($sformatf("b2b%0d_result", k), {16'd0, out_result}, {16'd0, vt[b2b[k]].res});
      chk($sformatf("b2b%0d_count", k), {27'd0, out_count}, vt[b2b[k]].cnt);
      chk($sformatf("b2b%0d_latency", k), lats[k], vt[b2b[k]].lat);
      @(posedge clk); #1;
    end
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("b2b%0d_gap", k), acc[k] - acc[k-1], vt[b2b[k-1]].lat + 2);
    end
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
